// File: rtl/filter_burst_loader.sv
// Filter burst loader: drains filter words from the upstream buffer into NUM_CH
// channel scratchpads, channel-major. Optional FBL_CHECKSUM_EN adds a running checksum output.
module filter_burst_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int NUM_CH = 3,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_read,
  input  logic [ADDR_W-1:0] filt_len,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ren,
  output logic              spad_wen,
  output logic [ADDR_W-1:0] spad_waddr,
  output logic [CH_W-1:0]   spad_ch,
  output logic [DATA_W-1:0] spad_wdata,
  input  logic              done,
  output logic              finish_read,
  output logic              busy
`ifdef FBL_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_POP     = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [CH_W-1:0]   CH_ONE   = CH_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
  logic [CH_W-1:0]     ch_cnt_q, ch_cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_word;

`ifdef FBL_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q, csum_d;

  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      ch_cnt_q   <= '0;
      data_q     <= '0;
`ifdef FBL_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      ch_cnt_q   <= ch_cnt_d;
      data_q     <= data_d;
`ifdef FBL_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign last_word = (word_cnt_q == len_q - ADDR_ONE);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    ch_cnt_d   = ch_cnt_q;
    data_d     = data_q;
`ifdef FBL_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_read) begin
          len_d      = filt_len;
          word_cnt_d = '0;
          ch_cnt_d   = '0;
          data_d     = '0;
`ifdef FBL_CHECKSUM_EN
          csum_d     = '0;
`endif
          state_d    = (filt_len == '0) ? S_FINISH : S_WAIT;
        end
      end
      S_WAIT: begin
        if (src_valid) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        data_d  = src_data;
        state_d = S_WRITE;
      end
      S_WRITE: begin
`ifdef FBL_CHECKSUM_EN
        csum_d  = wrap_add(csum_q, data_q);
`endif
        state_d = S_POP;
      end
      S_POP: begin
        // Counters advance after the pop so the address shown during WRITE is the word's own.
        if (last_word) begin
          word_cnt_d = '0;
          ch_cnt_d   = ch_cnt_q + CH_ONE;
          state_d    = (ch_cnt_q == LAST_CH) ? S_FINISH : S_WAIT;
        end else begin
          word_cnt_d = word_cnt_q + ADDR_ONE;
          state_d    = S_WAIT;
        end
      end
      S_FINISH: begin
        if (done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign src_ren     = (state_q == S_POP);
  assign spad_wen    = (state_q == S_WRITE);
  assign finish_read = (state_q == S_FINISH);
  assign busy        = (state_q != S_IDLE);
  assign spad_waddr  = word_cnt_q;
  assign spad_ch     = ch_cnt_q;
  assign spad_wdata  = data_q;
`ifdef FBL_CHECKSUM_EN
  assign checksum    = csum_q;
`endif

endmodule
